// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson ring sequencer: opcodes, state encoding
// and the legal-code test used by both the controller and its bench.
package johnson_pkg;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUN     = 2'b01;
  localparam logic [1:0] ST_RECOVER = 2'b11;

  // Widest ring is_johnson can examine; narrower rings are zero-extended.
  localparam int JW_MAX = 32;

  // Legal when at most one adjacent pair inside the low n bits differs.
  function automatic logic is_johnson(input logic [JW_MAX-1:0] v, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < JW_MAX - 1; i++) begin
      if ((i < n - 1) && (v[i] != v[i+1])) cnt++;
    end
    return (cnt <= 1);
  endfunction

endpackage

// File: rtl/johnson_stage_reg.sv
// One Johnson ring bit: D flip-flop with load enable plus asynchronous
// clear and preset (clear dominates).
module johnson_stage_reg (
  input  logic clk,
  input  logic i_clr,
  input  logic i_pre,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk or posedge i_clr or posedge i_pre) begin
    if (i_clr)      r_q <= 1'b0;
    else if (i_pre) r_q <= 1'b1;
    else if (i_en)  r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Command-driven sequencer for an N-stage Johnson ring: START/STOP/STEP/LOAD,
// bounded or free-running shifts, and recovery from non-Johnson ring states.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting; STEP shifts once, LOAD writes a legal code
// ST_RUN     | shifting every edge in latched dir until rem expires or STOP
// ST_RECOVER | one cycle: ring cleared to zero, err set, back to IDLE
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic             i_cmd_dir,
  input  logic [CNT_W-1:0] i_cmd_arg,
  output logic [N-1:0]     o_q,
  output logic             o_busy,
  output logic             o_tc,
  output logic             o_done,
  output logic             o_err,
  output logic [1:0]       o_state
);

  logic [1:0]       r_state;
  logic             r_dir;
  logic [CNT_W-1:0] r_rem;
  logic             r_tc;
  logic             r_done;
  logic             r_err;

  logic [N-1:0]      w_q;
  logic [N-1:0]      w_up;
  logic [N-1:0]      w_dn;
  logic [N-1:0]      w_ld;
  logic [N-1:0]      w_q_d;
  logic              w_q_en;
  logic              w_shift;
  logic              w_legal;
  logic              w_ld_legal;
  logic              w_accept;
  logic              w_stop;
  logic              w_run_step;
  logic              w_last;
  logic [JW_MAX-1:0] w_q_ext;
  logic [JW_MAX-1:0] w_ld_ext;

  for (genvar gi = 0; gi < N; gi++) begin : g_stage
    johnson_stage_reg u_stage (
      .clk   (clk),
      .i_clr (clr),
      .i_pre (1'b0),
      .i_en  (w_q_en),
      .i_d   (w_q_d[gi]),
      .o_q   (w_q[gi])
    );
  end

  assign w_up = {w_q[N-2:0], ~w_q[N-1]};
  assign w_dn = {~w_q[0], w_q[N-1:1]};
  assign w_ld = i_cmd_arg[N-1:0];

  assign w_q_ext    = {{(JW_MAX-N){1'b0}}, w_q};
  assign w_ld_ext   = {{(JW_MAX-N){1'b0}}, w_ld};
  assign w_legal    = is_johnson(w_q_ext, N);
  assign w_ld_legal = is_johnson(w_ld_ext, N);

  assign o_cmd_ready = (r_state != ST_RECOVER);
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_stop      = w_accept && (i_cmd_op == OP_STOP);
  // A STOP on the same edge as the final bounded step wins: no shift, no done.
  assign w_run_step  = (r_state == ST_RUN) && w_legal && !w_stop;
  assign w_last      = w_run_step && (r_rem == CNT_W'(1));

  always_comb begin
    w_q_en  = 1'b0;
    w_q_d   = w_q;
    w_shift = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_legal && w_accept) begin
          if (i_cmd_op == OP_STEP) begin
            w_q_en  = 1'b1;
            w_shift = 1'b1;
            w_q_d   = i_cmd_dir ? w_dn : w_up;
          end else if ((i_cmd_op == OP_LOAD) && w_ld_legal) begin
            w_q_en = 1'b1;
            w_q_d  = w_ld;
          end
        end
      end
      ST_RUN: begin
        if (w_run_step) begin
          w_q_en  = 1'b1;
          w_shift = 1'b1;
          w_q_d   = r_dir ? w_dn : w_up;
        end
      end
      ST_RECOVER: begin
        w_q_en = 1'b1;
        w_q_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_dir   <= 1'b0;
      r_rem   <= '0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // tc only follows shifts; a LOAD of zero or a recovery clear is silent.
      r_tc   <= w_shift && (w_q_d == '0);
      r_done <= w_last;
      case (r_state)
        ST_IDLE: begin
          if (!w_legal) begin
            r_state <= ST_RECOVER;
          end else if (w_accept) begin
            if (i_cmd_op == OP_START) begin
              r_state <= ST_RUN;
              r_dir   <= i_cmd_dir;
              r_rem   <= i_cmd_arg;
            end else if ((i_cmd_op == OP_LOAD) && !w_ld_legal) begin
              r_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!w_legal) begin
            r_state <= ST_RECOVER;
          end else if (w_stop) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
          end else if (r_rem != '0) begin
            r_rem <= r_rem - 1'b1;
            if (r_rem == CNT_W'(1)) r_state <= ST_IDLE;
          end
        end
        ST_RECOVER: begin
          r_err   <= 1'b1;
          r_rem   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_q     = w_q;
  assign o_busy  = (r_state == ST_RUN);
  assign o_tc    = r_tc;
  assign o_done  = r_done;
  assign o_err   = r_err;
  assign o_state = r_state;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl (N=4): stimulus queues hand-computed
// per-edge expectations, a monitor pops and compares them on falling edges.
module tb_johnson_seq_ctrl;
  import johnson_pkg::*;

  localparam int N     = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             clr;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_arg;
  logic [N-1:0]     q;
  logic             busy, tc, done, err;
  logic [1:0]       state;

  johnson_seq_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .clr         (clr),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_dir   (cmd_dir),
    .i_cmd_arg   (cmd_arg),
    .o_q         (q),
    .o_busy      (busy),
    .o_tc        (tc),
    .o_done      (done),
    .o_err       (err),
    .o_state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_edge = 0;
  always @(posedge clk) n_edge <= n_edge + 1;

  typedef struct {
    string      nm;
    int         at;
    logic [3:0] q;
    logic       tc;
    logic       done;
    logic       err;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // Expectation for the state visible after k more rising edges.
  task automatic push(input string nm, input int k, input logic [3:0] eq,
                      input logic etc, input logic edone, input logic eerr,
                      input logic [1:0] est);
    exp_t e;
    e.nm = nm; e.at = n_edge + k; e.q = eq; e.tc = etc;
    e.done = edone; e.err = eerr; e.st = est;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= n_edge) begin
        e = sb.pop_front();
        if (e.at < n_edge) chk({e.nm, ".late"}, n_edge, e.at);
        chk({e.nm, ".q"},     int'(q),         int'(e.q));
        chk({e.nm, ".tc"},    int'(tc),        int'(e.tc));
        chk({e.nm, ".done"},  int'(done),      int'(e.done));
        chk({e.nm, ".err"},   int'(err),       int'(e.err));
        chk({e.nm, ".state"}, int'(state),     int'(e.st));
        chk({e.nm, ".busy"},  int'(busy),      int'(e.st == ST_RUN));
        chk({e.nm, ".ready"}, int'(cmd_ready), int'(e.st != ST_RECOVER));
      end
    end
  end

  task automatic rst_chk(input string nm);
    chk({nm, ".q"},     int'(q),         0);
    chk({nm, ".state"}, int'(state),     int'(ST_IDLE));
    chk({nm, ".busy"},  int'(busy),      0);
    chk({nm, ".tc"},    int'(tc),        0);
    chk({nm, ".done"},  int'(done),      0);
    chk({nm, ".err"},   int'(err),       0);
    chk({nm, ".ready"}, int'(cmd_ready), 1);
  endtask

  // Called on a falling edge; holds the command for exactly one rising edge.
  task automatic issue(input logic [1:0] op, input logic dir, input logic [CNT_W-1:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_dir = dir; cmd_arg = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  logic [3:0] up_seq [9] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int nlegal;
    clr = 1'b1; cmd_valid = 1'b0; cmd_op = OP_STOP; cmd_dir = 1'b0; cmd_arg = '0;
    #1 rst_chk("rst_init");

    nlegal = 0;
    for (int v = 0; v < 16; v++) if (is_johnson(JW_MAX'(v), N)) nlegal++;
    chk("legal_code_count", nlegal, 2 * N);

    repeat (2) @(negedge clk);
    clr = 1'b0;
    push("idle", 1, 4'h0, 0, 0, 0, ST_IDLE);
    @(negedge clk);

    // free-run up from zero, then STOP
    push("fr_start", 1, 4'h0, 0, 0, 0, ST_RUN);
    for (int i = 0; i < 9; i++)
      push($sformatf("fr%0d", i + 1), i + 2, up_seq[i], (i == 7), 0, 0, ST_RUN);
    issue(OP_START, 1'b0, 8'd0);
    repeat (9) @(negedge clk);
    push("fr_stop", 1, 4'h1, 0, 0, 0, ST_IDLE);
    issue(OP_STOP, 1'b0, 8'd0);

    push("ld0", 1, 4'h0, 0, 0, 0, ST_IDLE);
    issue(OP_LOAD, 1'b0, 8'h00);

    // bounded START of 3 shifts, down
    push("b_start", 1, 4'h0, 0, 0, 0, ST_RUN);
    push("b1",      2, 4'h8, 0, 0, 0, ST_RUN);
    push("b2",      3, 4'hC, 0, 0, 0, ST_RUN);
    push("b3",      4, 4'hE, 0, 1, 0, ST_IDLE);
    push("b_after", 5, 4'hE, 0, 0, 0, ST_IDLE);
    issue(OP_START, 1'b1, 8'd3);
    repeat (4) @(negedge clk);

    push("ld_0111", 1, 4'h7, 0, 0, 0, ST_IDLE);
    issue(OP_LOAD, 1'b0, 8'h07);
    push("ld_0101", 1, 4'h7, 0, 0, 1, ST_IDLE);
    issue(OP_LOAD, 1'b0, 8'h05);
    push("step_up", 1, 4'hF, 0, 0, 1, ST_IDLE);
    issue(OP_STEP, 1'b0, 8'd0);
    push("step_dn", 1, 4'h7, 0, 0, 1, ST_IDLE);
    issue(OP_STEP, 1'b1, 8'd0);

    // STOP coinciding with the final bounded step
    push("s_start", 1, 4'h7, 0, 0, 1, ST_RUN);
    push("s1",      2, 4'hF, 0, 0, 1, ST_RUN);
    push("s_stop",  3, 4'hF, 0, 0, 1, ST_IDLE);
    push("s_after", 4, 4'hF, 0, 0, 1, ST_IDLE);
    issue(OP_START, 1'b0, 8'd2);
    @(negedge clk);
    issue(OP_STOP, 1'b0, 8'd0);
    @(negedge clk);

    // free-run down, then asynchronous clear mid-cycle
    push("fd_start", 1, 4'hF, 0, 0, 1, ST_RUN);
    push("fd1",      2, 4'h7, 0, 0, 1, ST_RUN);
    push("fd2",      3, 4'h3, 0, 0, 1, ST_RUN);
    issue(OP_START, 1'b1, 8'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 clr = 1'b1;
    #1 rst_chk("rst_midrun");
    @(negedge clk);
    clr = 1'b0;
    push("post_clr", 1, 4'h0, 0, 0, 0, ST_IDLE);
    @(negedge clk);

    // upset to 1010 with a command pending on the detection edge
    force dut.g_stage[1].u_stage.r_q = 1'b1;
    force dut.g_stage[3].u_stage.r_q = 1'b1;
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_dir = 1'b0; cmd_arg = 8'h01;
    push("rec_enter", 1, 4'hA, 0, 0, 0, ST_RECOVER);
    push("rec_clear", 2, 4'h0, 0, 0, 1, ST_IDLE);
    push("rec_after", 3, 4'h0, 0, 0, 1, ST_IDLE);
    #1 chk("upset.ready", int'(cmd_ready), 1);
    @(negedge clk);
    #1;
    release dut.g_stage[1].u_stage.r_q;
    release dut.g_stage[3].u_stage.r_q;
    @(negedge clk);
    cmd_valid = 1'b0;

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) chk("scoreboard_drain", sb.size(), 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
